// File: rtl/pipeline_hazard_scheduler_if.sv
// Hazard/sequencing bundle between the decode stage and the hazard scheduler.
//   master : decode side; drives the i_* hazard inputs, observes the o_* controls
//   slave  : pipeline_hazard_scheduler; reads i_*, drives o_*
// Signals:
//   i_id_rs/i_id_rt/i_id_uses_rt : operand fields of the instruction in ID
//   i_id_jump/i_id_halt          : jump / HALT decoded in ID
//   i_ex_memRead/i_ex_rt         : load in EX and its destination register
//   i_ex_branch_taken            : branch in EX resolved taken
//   i_step_mode/i_step           : debug single-step mode and step request level
//   o_pipe_en/o_pc_we/o_ifid_we  : pipeline, PC and IF/ID write enables
//   o_ifid_flush/o_idex_flush    : NOP into IF/ID, bubble into ID/EX
//   o_halted/o_state             : frozen-after-HALT flag, FSM state
//   o_cycle_count/o_stall_count  : enabled-cycle counter, saturating stall counter
interface pipeline_hazard_scheduler_if #(
  parameter int CNT_W   = 32,
  parameter int STALL_W = 16
);
  logic [4:0]         i_id_rs;
  logic [4:0]         i_id_rt;
  logic               i_id_uses_rt;
  logic               i_id_jump;
  logic               i_id_halt;
  logic               i_ex_memRead;
  logic [4:0]         i_ex_rt;
  logic               i_ex_branch_taken;
  logic               i_step_mode;
  logic               i_step;
  logic               o_pipe_en;
  logic               o_pc_we;
  logic               o_ifid_we;
  logic               o_ifid_flush;
  logic               o_idex_flush;
  logic               o_halted;
  logic [2:0]         o_state;
  logic [CNT_W-1:0]   o_cycle_count;
  logic [STALL_W-1:0] o_stall_count;

  modport master (
    output i_id_rs, i_id_rt, i_id_uses_rt, i_id_jump, i_id_halt,
           i_ex_memRead, i_ex_rt, i_ex_branch_taken, i_step_mode, i_step,
    input  o_pipe_en, o_pc_we, o_ifid_we, o_ifid_flush, o_idex_flush,
           o_halted, o_state, o_cycle_count, o_stall_count
  );

  modport slave (
    input  i_id_rs, i_id_rt, i_id_uses_rt, i_id_jump, i_id_halt,
           i_ex_memRead, i_ex_rt, i_ex_branch_taken, i_step_mode, i_step,
    output o_pipe_en, o_pc_we, o_ifid_we, o_ifid_flush, o_idex_flush,
           o_halted, o_state, o_cycle_count, o_stall_count
  );
endinterface

// File: rtl/pipeline_hazard_scheduler.sv
// Central sequencing controller for the 5-stage MIPS pipeline.
// Resolves load-use stalls, branch/jump flushes, debug single-step and HALT
// drain, and keeps cycle/stall counters for the debug unit.
// Ports:
//   clk   : system clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : hazard inputs and pipeline controls (slave side)
// Parameters:
//   DRAIN_CYCLES : bubble cycles after HALT leaves ID before the freeze
//   CNT_W        : width of o_cycle_count (wraps)
//   STALL_W      : width of o_stall_count (saturates)
module pipeline_hazard_scheduler #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32,
  parameter int STALL_W      = 16
) (
  input logic                         clk,
  input logic                         i_rst,
  pipeline_hazard_scheduler_if.slave  bus
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    FROZEN = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic               step_q;
  logic [DW-1:0]      drain_cnt, drain_nxt;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [STALL_W-1:0] stall_cnt;

  logic step_pulse, active, load_use, stall_inc;
  logic pipe_en, pc_we, ifid_we, ifid_flush, idex_flush, halted;

  assign step_pulse = bus.i_step & ~step_q;
  assign active     = ((state == RUN) && !bus.i_step_mode) || (state == STEP);
  assign load_use   = bus.i_ex_memRead && (bus.i_ex_rt != '0) &&
                      ((bus.i_ex_rt == bus.i_id_rs) ||
                       (bus.i_id_uses_rt && (bus.i_ex_rt == bus.i_id_rt)));

  always_comb begin
    state_nxt  = state;
    drain_nxt  = drain_cnt;
    stall_inc  = 1'b0;
    pipe_en    = active;
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;

    case (state)
      RUN:    if (bus.i_step_mode) state_nxt = FROZEN;
      FROZEN: begin
        if (!bus.i_step_mode)  state_nxt = RUN;
        else if (step_pulse)   state_nxt = STEP;
      end
      STEP:   state_nxt = FROZEN;
      DRAIN: begin
        pipe_en    = 1'b1;
        idex_flush = 1'b1;
        drain_nxt  = drain_cnt - DW'(1);
        if (drain_cnt <= DW'(1)) state_nxt = HALTED;
      end
      HALTED: halted = 1'b1;
      default: state_nxt = RUN;
    endcase

    // Hazard decode; a taken halt overrides the STEP->FROZEN return.
    if (active) begin
      if (bus.i_ex_branch_taken) begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end else if (bus.i_id_halt) begin
        idex_flush = 1'b1;
        drain_nxt  = DW'(DRAIN_CYCLES);
        state_nxt  = DRAIN;
      end else if (bus.i_id_jump) begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b1;
      end else begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= RUN;
      step_q    <= 1'b0;
      drain_cnt <= '0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      step_q    <= bus.i_step;
      drain_cnt <= drain_nxt;
      if (pipe_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  assign bus.o_pipe_en     = pipe_en;
  assign bus.o_pc_we       = pc_we;
  assign bus.o_ifid_we     = ifid_we;
  assign bus.o_ifid_flush  = ifid_flush;
  assign bus.o_idex_flush  = idex_flush;
  assign bus.o_halted      = halted;
  assign bus.o_state       = state;
  assign bus.o_cycle_count = cycle_cnt;
  assign bus.o_stall_count = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// Scoreboard bench for pipeline_hazard_scheduler. Each directed vector drives
// the hazard inputs for one cycle and queues the hand-computed outputs; a
// negedge monitor pops and compares control bits, state, halted and counters.
module tb_pipeline_hazard_scheduler;

  localparam logic [2:0] S_RUN = 3'd0, S_FRZ = 3'd1, S_STP = 3'd2,
                         S_DRN = 3'd3, S_HLT = 3'd4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_scheduler_if #(.CNT_W(32), .STALL_W(16)) bus ();

  pipeline_hazard_scheduler #(
    .DRAIN_CYCLES (3),
    .CNT_W        (32),
    .STALL_W      (16)
  ) dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [4:0]  ctl;  // {pipe_en, pc_we, ifid_we, ifid_flush, idex_flush}
    logic        halted;
    logic [2:0]  st;
    logic [31:0] cyc;
    logic [15:0] stl;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          tests  = 0;
  int          fails  = 0;
  int          vec_id = 0;
  logic [31:0] exp_cyc = '0;
  logic [15:0] exp_stl = '0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want, input int id);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s vec%0d: got %0h expected %0h", name, id, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ctl", {27'd0, bus.o_pipe_en, bus.o_pc_we, bus.o_ifid_we,
                  bus.o_ifid_flush, bus.o_idex_flush}, {27'd0, e.ctl}, e.id);
      chk("halted", {31'd0, bus.o_halted}, {31'd0, e.halted}, e.id);
      chk("state", {29'd0, bus.o_state}, {29'd0, e.st}, e.id);
      chk("cycle_count", bus.o_cycle_count, e.cyc, e.id);
      chk("stall_count", {16'd0, bus.o_stall_count}, {16'd0, e.stl}, e.id);
    end
  end

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic jmp, input logic hlt,
                        input logic mrd, input logic [4:0] ert, input logic br,
                        input logic smode, input logic stp, input logic r);
    bus.i_id_rs           = rs;
    bus.i_id_rt           = rt;
    bus.i_id_uses_rt      = urt;
    bus.i_id_jump         = jmp;
    bus.i_id_halt         = hlt;
    bus.i_ex_memRead      = mrd;
    bus.i_ex_rt           = ert;
    bus.i_ex_branch_taken = br;
    bus.i_step_mode       = smode;
    bus.i_step            = stp;
    rst                   = r;
  endtask

  // Queue this cycle's expected outputs, then advance one clock.
  task automatic expect_cyc(input logic [4:0] ctl, input logic h,
                            input logic [2:0] st, input logic stall_hit);
    exp_t e;
    e.ctl = ctl; e.halted = h; e.st = st;
    e.cyc = exp_cyc; e.stl = exp_stl; e.id = vec_id;
    sb.push_back(e);
    vec_id++;
    if (rst) begin
      exp_cyc = '0;
      exp_stl = '0;
    end else begin
      exp_cyc = exp_cyc + {31'd0, ctl[4]};
      if (stall_hit) exp_stl = exp_stl + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  // ADDU $3,$1,$2 in ID, no EX hazard.
  task automatic addu(input logic smode, input logic stp, input logic r);
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, smode, stp, r);
  endtask

  initial begin
    addu(1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // reset state, then plain RUN
    addu(0, 0, 0); expect_cyc(5'b11100, 0, S_RUN, 0);
    addu(0, 0, 0); expect_cyc(5'b11100, 0, S_RUN, 0);
    addu(0, 0, 0); expect_cyc(5'b11100, 0, S_RUN, 0);

    // load-use on rt, then the bubble clears it
    set_in(5'd1, 5'd2, 1, 0, 0, 1, 5'd2, 0, 0, 0, 0); expect_cyc(5'b10001, 0, S_RUN, 1);
    addu(0, 0, 0); expect_cyc(5'b11100, 0, S_RUN, 0);
    // load to $0 never stalls, even with rs=rt=0
    set_in(5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, 0, 0, 0); expect_cyc(5'b11100, 0, S_RUN, 0);
    // rt match ignored when ID does not read rt
    set_in(5'd1, 5'd2, 0, 0, 0, 1, 5'd2, 0, 0, 0, 0); expect_cyc(5'b11100, 0, S_RUN, 0);
    // rs match stalls regardless of uses_rt
    set_in(5'd1, 5'd2, 0, 0, 0, 1, 5'd1, 0, 0, 0, 0); expect_cyc(5'b10001, 0, S_RUN, 1);

    // branch beats load-use and halt
    set_in(5'd1, 5'd2, 1, 0, 1, 1, 5'd2, 1, 0, 0, 0); expect_cyc(5'b11111, 0, S_RUN, 0);
    addu(0, 0, 0); expect_cyc(5'b11100, 0, S_RUN, 0);

    // J 16
    set_in(5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0, 0, 0); expect_cyc(5'b11110, 0, S_RUN, 0);
    addu(0, 0, 0); expect_cyc(5'b11100, 0, S_RUN, 0);

    // single step: step held 5 cycles gives one enabled cycle
    addu(1, 0, 0); expect_cyc(5'b00000, 0, S_RUN, 0);
    addu(1, 0, 0); expect_cyc(5'b00000, 0, S_FRZ, 0);
    addu(1, 1, 0); expect_cyc(5'b00000, 0, S_FRZ, 0);
    addu(1, 1, 0); expect_cyc(5'b11100, 0, S_STP, 0);
    addu(1, 1, 0); expect_cyc(5'b00000, 0, S_FRZ, 0);
    addu(1, 1, 0); expect_cyc(5'b00000, 0, S_FRZ, 0);
    addu(1, 1, 0); expect_cyc(5'b00000, 0, S_FRZ, 0);
    addu(1, 0, 0); expect_cyc(5'b00000, 0, S_FRZ, 0);
    addu(0, 0, 0); expect_cyc(5'b00000, 0, S_FRZ, 0);
    addu(0, 0, 0); expect_cyc(5'b11100, 0, S_RUN, 0);

    // leaving step mode wins over a simultaneous step edge
    addu(1, 0, 0); expect_cyc(5'b00000, 0, S_RUN, 0);
    addu(0, 1, 0); expect_cyc(5'b00000, 0, S_FRZ, 0);
    addu(0, 0, 0); expect_cyc(5'b11100, 0, S_RUN, 0);

    // halt taken during STEP; drain runs despite step mode, then freeze
    addu(1, 0, 0); expect_cyc(5'b00000, 0, S_RUN, 0);
    addu(1, 0, 0); expect_cyc(5'b00000, 0, S_FRZ, 0);
    addu(1, 1, 0); expect_cyc(5'b00000, 0, S_FRZ, 0);
    set_in(5'd1, 5'd2, 1, 0, 1, 0, 5'd0, 0, 1, 1, 0); expect_cyc(5'b10001, 0, S_STP, 0);
    addu(1, 1, 0); expect_cyc(5'b10001, 0, S_DRN, 0);
    addu(1, 0, 0); expect_cyc(5'b10001, 0, S_DRN, 0);
    addu(1, 0, 0); expect_cyc(5'b10001, 0, S_DRN, 0);
    addu(0, 0, 0); expect_cyc(5'b00000, 1, S_HLT, 0);
    set_in(5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 1, 0, 1, 0); expect_cyc(5'b00000, 1, S_HLT, 0);
    addu(0, 0, 1); expect_cyc(5'b00000, 1, S_HLT, 0);
    addu(0, 0, 0); expect_cyc(5'b11100, 0, S_RUN, 0);

    // halt in RUN, reset during DRAIN (branch in DRAIN ignored)
    set_in(5'd1, 5'd2, 1, 0, 1, 0, 5'd0, 0, 0, 0, 0); expect_cyc(5'b10001, 0, S_RUN, 0);
    set_in(5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 1, 0, 0, 0); expect_cyc(5'b10001, 0, S_DRN, 0);
    addu(0, 0, 1); expect_cyc(5'b10001, 0, S_DRN, 0);
    addu(0, 0, 0); expect_cyc(5'b11100, 0, S_RUN, 0);

    // full halt: 1 halt cycle + 3 drain cycles, then frozen for good
    set_in(5'd1, 5'd2, 1, 0, 1, 0, 5'd0, 0, 0, 0, 0); expect_cyc(5'b10001, 0, S_RUN, 0);
    addu(0, 0, 0); expect_cyc(5'b10001, 0, S_DRN, 0);
    addu(0, 0, 0); expect_cyc(5'b10001, 0, S_DRN, 0);
    addu(0, 0, 0); expect_cyc(5'b10001, 0, S_DRN, 0);
    addu(0, 0, 0); expect_cyc(5'b00000, 1, S_HLT, 0);
    addu(0, 0, 0); expect_cyc(5'b00000, 1, S_HLT, 0);
    addu(0, 0, 0); expect_cyc(5'b00000, 1, S_HLT, 0);

    repeat (2) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
